// File: rtl/fft_bf_pkg.sv
// Shared FFT pipeline package.
// Holds the frame length, the per-stage sub-transform length rule, the index
// and twiddle-address width rules, and the per-stage bit-growth rule. Both the
// butterfly stage and the twiddle multiplier instantiation size their ports
// from these functions so the stages always agree on widths.
package fft_bf_pkg;

  localparam int FFT_N = 1024;

  // Delay lines at or above this depth are built as synchronous-read block RAM.
  // Shallower ones are built from flops with an asynchronous read.
  localparam int RAM_BRAM_MIN = 32;

  // Sub-transform length handled by pipeline stage 'stage' (0 = first stage).
  function automatic int stage_len(input int n, input int stage);
    return n >> stage;
  endfunction

  // Width of the in-frame sample index.
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  // Width of the twiddle ROM index. It covers N/2 entries and is kept at least
  // one bit wide.
  function automatic int addr_w(input int n);
    return ($clog2(n) > 1) ? $clog2(n) - 1 : 1;
  endfunction

  // Each radix-2 stage grows the sample width by one bit.
  function automatic int grow_w(input int w);
    return w + 1;
  endfunction

  // Butterfly select: the first half of each sub-transform is stored; the second half is combined with it.
  typedef enum logic {
    SEL_STORE = 1'b0,
    SEL_BFLY  = 1'b1
  } bf_sel_e;

endpackage

// File: rtl/fft_bf_if.sv
// Streaming sample bus between FFT pipeline stages.
// Input side:  carry_in (frame valid carry), ctr_i (sample index in frame),
//              x_re_i / x_im_i (signed WIDTH-bit sample).
// Output side: carry_out, ctr_o, z_re_o / z_im_o (signed WIDTH+1-bit result),
//              w_addr_o (twiddle ROM index aligned with z).
// The master modport drives the input side and observes the output side.
// The slave modport belongs to the butterfly stage.
interface fft_bf_if import fft_bf_pkg::*; #(
  parameter int WIDTH = 24,
  parameter int N     = FFT_N
) ();

  localparam int IW = idx_w(N);
  localparam int AW = addr_w(N);
  localparam int OW = grow_w(WIDTH);

  logic                    carry_in;
  logic [IW-1:0]           ctr_i;
  logic signed [WIDTH-1:0] x_re_i;
  logic signed [WIDTH-1:0] x_im_i;

  logic                    carry_out;
  logic [IW-1:0]           ctr_o;
  logic signed [OW-1:0]    z_re_o;
  logic signed [OW-1:0]    z_im_o;
  logic [AW-1:0]           w_addr_o;

  modport master (
    output carry_in, ctr_i, x_re_i, x_im_i,
    input  carry_out, ctr_o, z_re_o, z_im_o, w_addr_o
  );

  modport slave (
    input  carry_in, ctr_i, x_re_i, x_im_i,
    output carry_out, ctr_o, z_re_o, z_im_o, w_addr_o
  );

endinterface

// File: rtl/fft_delay_ram.sv
// Circular delay line for the SDF butterfly feedback path.
// Every cycle, the entry at the single pointer is read and then overwritten.
// The read returns the old contents. The pointer wraps after DEPTH-1.
// Ports:
//   clk, arst_n  clock and asynchronous active-low reset (pointer/flag only)
//   wr_data      entry written at the current pointer
//   rd_data      entry previously stored at the current pointer
//   primed       high once every entry has been written since reset
// Storage contents are never reset.
module fft_delay_ram import fft_bf_pkg::*; #(
  parameter int DEPTH = 512,
  parameter int DW    = 51
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          primed
);

  localparam int            PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;

  assign ptr_nxt = (ptr == P_LAST) ? '0 : ptr + PW'(1);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr    <= '0;
      primed <= 1'b0;
    end else begin
      ptr <= ptr_nxt;
      if (ptr == P_LAST)
        primed <= 1'b1;
    end
  end

  if (DEPTH == 1) begin : g_reg
    logic [DW-1:0] q;
    always_ff @(posedge clk)
      q <= wr_data;
    assign rd_data = q;
  end else if (DEPTH >= RAM_BRAM_MIN) begin : g_bram
    // Synchronous-read RAM: fetch the entry for the next pointer one cycle ahead.
    // With DEPTH >= 2, that entry is never the one being written this cycle.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q;
    always_ff @(posedge clk) begin
      mem[ptr] <= wr_data;
      rd_q     <= mem[ptr_nxt];
    end
    assign rd_data = rd_q;
  end else begin : g_flop
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk)
      mem[ptr] <= wr_data;
    assign rd_data = mem[ptr];
  end

endmodule

// File: rtl/fft_bf.sv
// Radix-2 DIF single-path delay-feedback butterfly stage.
// The first half of each STAGE_LEN sub-transform is held in an L/2-deep
// feedback delay line. In the second half, the stage emits x[n]+x[n+L/2] and
// stores x[n]-x[n+L/2]. Those differences are emitted during the following
// half-sub-transform. Outputs grow by one bit, so nothing wraps.
// Ports:
//   clk     stage clock, one sample per cycle, no backpressure
//   arst_n  asynchronous active-low reset
//   bf      stream bus (slave side): carry/ctr/x in, carry/ctr/z/w_addr out
// Latency is STAGE_LEN/2+1 cycles. This relies on ctr_i incrementing every
// cycle.
module fft_bf import fft_bf_pkg::*; #(
  parameter int WIDTH     = 24,
  parameter int N         = FFT_N,
  parameter int STAGE_LEN = FFT_N
) (
  input logic   clk,
  input logic   arst_n,
  fft_bf_if.slave bf
);

  localparam int IW = idx_w(N);
  localparam int AW = addr_w(N);
  localparam int OW = grow_w(WIDTH);
  localparam int LH = STAGE_LEN / 2;
  localparam int LW = $clog2(STAGE_LEN);
  localparam int DW = 2 * OW + 1;

  localparam logic [IW-1:0] LH_I   = IW'(LH);
  localparam logic [IW-1:0] L_MASK = IW'(STAGE_LEN - 1);
  localparam logic [IW-1:0] W_STEP = IW'(N / STAGE_LEN);

  function automatic logic signed [OW-1:0] sext(input logic signed [WIDTH-1:0] v);
    return {v[WIDTH-1], v};
  endfunction

  bf_sel_e              sel;
  logic signed [OW-1:0] x_re, x_im;
  logic signed [OW-1:0] d_re, d_im;
  logic signed [OW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic signed [OW-1:0] z_re_nxt, z_im_nxt;
  logic                 d_carry;
  logic                 primed;
  logic [DW-1:0]        wr_data;
  logic [DW-1:0]        rd_data;
  logic [IW-1:0]        ctr_nxt;
  logic [IW-1:0]        m_nxt;
  logic [AW-1:0]        w_nxt;

  // Stage p0: butterfly arithmetic against the delay-line read data
  assign sel  = bf_sel_e'(bf.ctr_i[LW-1]);
  assign x_re = sext(bf.x_re_i);
  assign x_im = sext(bf.x_im_i);

  assign {d_re, d_im, d_carry} = rd_data;

  assign sum_re = d_re + x_re;
  assign sum_im = d_im + x_im;
  assign dif_re = d_re - x_re;
  assign dif_im = d_im - x_im;

  always_comb begin
    z_re_nxt = d_re;
    z_im_nxt = d_im;
    wr_data  = {x_re, x_im, bf.carry_in};
    if (sel == SEL_BFLY) begin
      z_re_nxt = sum_re;
      z_im_nxt = sum_im;
      wr_data  = {dif_re, dif_im, bf.carry_in};
    end
  end

  fft_delay_ram #(
    .DEPTH (LH),
    .DW    (DW)
  ) u_dly (
    .clk     (clk),
    .arst_n  (arst_n),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .primed  (primed)
  );

  // Output index and its twiddle: m = local index of the emitted sample.
  // The second half of a sub-transform takes W^((m-L/2)*N/L); the first half takes W^0.
  assign ctr_nxt = bf.ctr_i - LH_I;
  assign m_nxt   = ctr_nxt & L_MASK;

  always_comb begin
    w_nxt = '0;
    if (m_nxt >= LH_I)
      w_nxt = AW'((m_nxt - LH_I) * W_STEP);
  end

  // Stage p1: output register
  logic signed [OW-1:0] z_re_p1, z_im_p1;
  logic [IW-1:0]        ctr_p1;
  logic [AW-1:0]        w_addr_p1;
  logic                 vld_p1;

  // Carry bits read before the line refills after reset are stale and must not
  // raise carry_out.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      z_re_p1   <= '0;
      z_im_p1   <= '0;
      ctr_p1    <= '0;
      w_addr_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      z_re_p1   <= z_re_nxt;
      z_im_p1   <= z_im_nxt;
      ctr_p1    <= ctr_nxt;
      w_addr_p1 <= w_nxt;
      vld_p1    <= d_carry & primed;
    end
  end

  assign bf.z_re_o    = z_re_p1;
  assign bf.z_im_o    = z_im_p1;
  assign bf.ctr_o     = ctr_p1;
  assign bf.w_addr_o  = w_addr_p1;
  assign bf.carry_out = vld_p1;

endmodule

// File: tb/tb_fft_bf.sv
// Directed bench for fft_bf. It uses three stage configurations:
//   A: N=8,    L=8, WIDTH=4   impulse, bit growth, sign extension, mid-frame reset
//   B: N=8,    L=4, WIDTH=4   ramp with twiddle addresses
//   C: N=1024, L=2, WIDTH=12  last stage, random stream against a golden formula
// Inputs change one time unit after each rising edge. After rising edge P_k,
// the output carries index k-L/2.
module tb_fft_bf;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fft_bf_if #(.WIDTH(4),  .N(8))    ifa ();
  fft_bf_if #(.WIDTH(4),  .N(8))    ifb ();
  fft_bf_if #(.WIDTH(12), .N(1024)) ifc ();

  fft_bf #(.WIDTH(4),  .N(8),    .STAGE_LEN(8)) dut_a (.clk(clk), .arst_n(arst_n), .bf(ifa));
  fft_bf #(.WIDTH(4),  .N(8),    .STAGE_LEN(4)) dut_b (.clk(clk), .arst_n(arst_n), .bf(ifb));
  fft_bf #(.WIDTH(12), .N(1024), .STAGE_LEN(2)) dut_c (.clk(clk), .arst_n(arst_n), .bf(ifc));

  task automatic drive_a(input int k, input logic c, input int re, input int im);
    ifa.carry_in = c;
    ifa.ctr_i    = 3'(k);
    ifa.x_re_i   = 4'(re);
    ifa.x_im_i   = 4'(im);
  endtask

  task automatic drive_b(input int k, input logic c, input int re, input int im);
    ifb.carry_in = c;
    ifb.ctr_i    = 3'(k);
    ifb.x_re_i   = 4'(re);
    ifb.x_im_i   = 4'(im);
  endtask

  task automatic drive_c(input int k, input logic c, input int re, input int im);
    ifc.carry_in = c;
    ifc.ctr_i    = 10'(k);
    ifc.x_re_i   = 12'(re);
    ifc.x_im_i   = 12'(im);
  endtask

  // Leaves the bench at a falling edge with reset just released, so the next
  // rising edge takes index 0.
  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0;
    drive_a(0, 1'b0, 0, 0);
    drive_b(0, 1'b0, 0, 0);
    drive_c(0, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    arst_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      drive_a(r + 5, 1'b1, 3, -2);
      drive_b(r + 5, 1'b1, 5, 4);
      drive_c(r + 7, 1'b1, 100, -100);
      @(posedge clk); #1;
      checks++;
      if ({ifa.carry_out, ifa.ctr_o, ifa.w_addr_o, ifa.z_re_o, ifa.z_im_o} !== '0) begin
        errors++;
        $display("FAIL reset_a: carry=%b ctr=%0d w=%0d re=%0d im=%0d, want all 0",
                 ifa.carry_out, ifa.ctr_o, ifa.w_addr_o, ifa.z_re_o, ifa.z_im_o);
      end
      checks++;
      if ({ifb.carry_out, ifb.ctr_o, ifb.w_addr_o, ifb.z_re_o, ifb.z_im_o} !== '0) begin
        errors++;
        $display("FAIL reset_b: carry=%b ctr=%0d w=%0d re=%0d im=%0d, want all 0",
                 ifb.carry_out, ifb.ctr_o, ifb.w_addr_o, ifb.z_re_o, ifb.z_im_o);
      end
      checks++;
      if ({ifc.carry_out, ifc.ctr_o, ifc.w_addr_o, ifc.z_re_o, ifc.z_im_o} !== '0) begin
        errors++;
        $display("FAIL reset_c: carry=%b ctr=%0d w=%0d re=%0d im=%0d, want all 0",
                 ifc.carry_out, ifc.ctr_o, ifc.w_addr_o, ifc.z_re_o, ifc.z_im_o);
      end
    end
  endtask

  task automatic test_impulse();
    int exp_re [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    int exp_w  [8] = '{0, 0, 0, 0, 0, 1, 2, 3};
    logic signed [4:0] e;
    int j;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive_a(k, 1'b1, (k == 0) ? 1 : 0, 0);
      @(posedge clk); #1;
      checks++;
      if (ifa.carry_out !== (k >= 4)) begin
        errors++;
        $display("FAIL imp_carry k=%0d: got %b want %b", k, ifa.carry_out, (k >= 4));
      end
      if (k >= 4) begin
        j = k - 4;
        e = 5'(exp_re[j]);
        checks++;
        if (ifa.z_re_o !== e) begin
          errors++;
          $display("FAIL imp_re j=%0d: got %0d want %0d", j, ifa.z_re_o, e);
        end
        checks++;
        if (ifa.z_im_o !== 5'sd0) begin
          errors++;
          $display("FAIL imp_im j=%0d: got %0d want 0", j, ifa.z_im_o);
        end
        checks++;
        if (ifa.ctr_o !== 3'(j)) begin
          errors++;
          $display("FAIL imp_ctr j=%0d: got %0d want %0d", j, ifa.ctr_o, j);
        end
        checks++;
        if (ifa.w_addr_o !== 2'(exp_w[j])) begin
          errors++;
          $display("FAIL imp_w j=%0d: got %0d want %0d", j, ifa.w_addr_o, exp_w[j]);
        end
      end
    end
  endtask

  // Frame 0 is all 7. Frame 1 is 7 then -8 by half. Frame 2 is all -8.
  task automatic test_growth();
    int exp_re [24] = '{14, 14, 14, 14, 0, 0, 0, 0,
                        -1, -1, -1, -1, 15, 15, 15, 15,
                        -16, -16, -16, -16, 0, 0, 0, 0};
    logic signed [4:0] e;
    int j;
    do_reset();
    for (int k = 0; k < 28; k++) begin
      drive_a(k, 1'b1, (k < 12) ? 7 : ((k < 24) ? -8 : 0), 0);
      @(posedge clk); #1;
      if (k >= 4) begin
        j = k - 4;
        e = 5'(exp_re[j]);
        checks++;
        if (ifa.z_re_o !== e) begin
          errors++;
          $display("FAIL grow_re j=%0d: got %0d want %0d", j, ifa.z_re_o, e);
        end
        if (j == 16) begin
          checks++;
          if (ifa.z_re_o !== 5'b10000) begin
            errors++;
            $display("FAIL grow_sext: got %b want 10000", ifa.z_re_o);
          end
        end
      end
    end
  endtask

  task automatic test_ramp();
    int exp_re [8] = '{2, 4, -2, -2, 10, 12, -2, -2};
    int exp_w  [8] = '{0, 0, 0, 2, 0, 0, 0, 2};
    logic signed [4:0] er, ei;
    int j;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive_b(k, 1'b1, (k < 8) ? k : 0, (k < 8) ? -k : 0);
      @(posedge clk); #1;
      if (k >= 2) begin
        j  = k - 2;
        er = 5'(exp_re[j]);
        ei = 5'(-exp_re[j]);
        checks++;
        if (ifb.z_re_o !== er) begin
          errors++;
          $display("FAIL ramp_re j=%0d: got %0d want %0d", j, ifb.z_re_o, er);
        end
        checks++;
        if (ifb.z_im_o !== ei) begin
          errors++;
          $display("FAIL ramp_im j=%0d: got %0d want %0d", j, ifb.z_im_o, ei);
        end
        checks++;
        if (ifb.w_addr_o !== 2'(exp_w[j]) || ifb.ctr_o !== 3'(j) || ifb.carry_out !== 1'b1) begin
          errors++;
          $display("FAIL ramp_ctl j=%0d: got w=%0d ctr=%0d carry=%b want w=%0d ctr=%0d carry=1",
                   j, ifb.w_addr_o, ifb.ctr_o, ifb.carry_out, exp_w[j], j);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic signed [4:0] e;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive_a(k, 1'b1, 3, 1);
      @(posedge clk); #1;
    end
    checks++;
    if (ifa.carry_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_carry: got %b want 1", ifa.carry_out);
    end
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    checks++;
    if ({ifa.carry_out, ifa.ctr_o, ifa.w_addr_o, ifa.z_re_o, ifa.z_im_o} !== '0) begin
      errors++;
      $display("FAIL mid_async: carry=%b ctr=%0d w=%0d re=%0d im=%0d, want all 0",
               ifa.carry_out, ifa.ctr_o, ifa.w_addr_o, ifa.z_re_o, ifa.z_im_o);
    end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive_a(k, 1'b1, (k == 0) ? 2 : 0, 0);
      @(posedge clk); #1;
      checks++;
      if (ifa.carry_out !== (k >= 4)) begin
        errors++;
        $display("FAIL mid_carry k=%0d: got %b want %b", k, ifa.carry_out, (k >= 4));
      end
      if (k >= 4) begin
        e = ((k - 4) % 4 == 0) ? 5'sd2 : 5'sd0;
        checks++;
        if (ifa.z_re_o !== e || ifa.ctr_o !== 3'(k - 4)) begin
          errors++;
          $display("FAIL mid_data k=%0d: got re=%0d ctr=%0d want re=%0d ctr=%0d",
                   k, ifa.z_re_o, ifa.ctr_o, e, k - 4);
        end
      end
    end
  endtask

  task automatic test_last_stage();
    int xr [200];
    int xi [200];
    int lim [8] = '{-2048, -2048, 2047, 2047, -2048, 2047, 2047, -2048};
    logic signed [12:0] er, ei;
    int j;
    for (int i = 0; i < 200; i++) begin
      xr[i] = (i < 8) ? lim[i] : int'($urandom_range(4095)) - 2048;
      xi[i] = (i < 8) ? lim[7 - i] : int'($urandom_range(4095)) - 2048;
    end
    do_reset();
    for (int k = 0; k <= 200; k++) begin
      drive_c(k, 1'b1, (k < 200) ? xr[k] : 0, (k < 200) ? xi[k] : 0);
      @(posedge clk); #1;
      if (k == 0) begin
        checks++;
        if (ifc.carry_out !== 1'b0 || ifc.ctr_o !== 10'd1023) begin
          errors++;
          $display("FAIL last_first: got carry=%b ctr=%0d want carry=0 ctr=1023",
                   ifc.carry_out, ifc.ctr_o);
        end
      end else begin
        j  = k - 1;
        er = (j % 2 == 0) ? 13'(xr[j] + xr[j + 1]) : 13'(xr[j - 1] - xr[j]);
        ei = (j % 2 == 0) ? 13'(xi[j] + xi[j + 1]) : 13'(xi[j - 1] - xi[j]);
        checks++;
        if (ifc.z_re_o !== er) begin
          errors++;
          $display("FAIL last_re j=%0d: got %0d want %0d", j, ifc.z_re_o, er);
        end
        checks++;
        if (ifc.z_im_o !== ei) begin
          errors++;
          $display("FAIL last_im j=%0d: got %0d want %0d", j, ifc.z_im_o, ei);
        end
        checks++;
        if (ifc.ctr_o !== 10'(j) || ifc.w_addr_o !== 9'd0 || ifc.carry_out !== 1'b1) begin
          errors++;
          $display("FAIL last_ctl j=%0d: got ctr=%0d w=%0d carry=%b want ctr=%0d w=0 carry=1",
                   j, ifc.ctr_o, ifc.w_addr_o, ifc.carry_out, j);
        end
      end
    end
  endtask

  initial begin
    drive_a(0, 1'b0, 0, 0);
    drive_b(0, 1'b0, 0, 0);
    drive_c(0, 1'b0, 0, 0);
    test_reset();
    test_impulse();
    test_growth();
    test_ramp();
    test_mid_reset();
    test_last_stage();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
